// File: rtl/panda_risc_v_ifu_pkg.sv
// Shared IFU definitions: fetch-PC sequencer state encoding and address width.
package panda_risc_v_ifu_pkg;

  localparam int IMEM_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_RST_REQ    = 2'd0,
    ST_REQ        = 2'd1,
    ST_WAIT       = 2'd2,
    ST_JALR_STALL = 2'd3
  } pc_seq_state_e;

endpackage

// File: rtl/panda_risc_v_pc_seq.sv
// Fetch-PC sequencer: owns the fetch PC, issues one imem request at a time,
// holds JALR until RS1 is ready and buffers accepted instructions for decode.
//   state         | meaning
//   ST_RST_REQ    | ask next-PC generator for reset PC and load it
//   ST_REQ        | present fetch request for now_pc
//   ST_WAIT       | waiting for the fetch response
//   ST_JALR_STALL | JALR captured, waiting for rs1_vld
module panda_risc_v_pc_seq
  import panda_risc_v_ifu_pkg::*;
#(
  parameter int simulation_delay = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IMEM_ADDR_W-1:0] rst_pc,
  input  logic                   flush_req,
  input  logic [IMEM_ADDR_W-1:0] flush_addr,
  output logic [IMEM_ADDR_W-1:0] now_pc,
  output logic                   to_rst,
  output logic                   to_flush,
  output logic [IMEM_ADDR_W-1:0] flush_addr_hold,
  input  logic [IMEM_ADDR_W-1:0] new_pc,
  input  logic                   to_jump,
  input  logic                   is_jalr_inst,
  input  logic                   rs1_vld,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [IMEM_ADDR_W-1:0] imem_req_addr,
  input  logic                   imem_resp_valid,
  output logic                   imem_resp_ready,
  input  logic [31:0]            imem_resp_inst,
  output logic                   if_out_valid,
  input  logic                   if_out_ready,
  output logic [31:0]            if_out_inst,
  output logic [IMEM_ADDR_W-1:0] if_out_pc,
  output logic                   if_out_prdt_jump
);

  // rst_pc reaches now_pc through the external generator while to_rst is high.
  localparam int unused_sim_delay = simulation_delay;
  logic unused_rst_pc;
  assign unused_rst_pc = ^rst_pc;

  pc_seq_state_e state_q, state_d;
  logic [IMEM_ADDR_W-1:0] now_pc_q, now_pc_d;
  logic                   flush_pending_q, flush_pending_d;
  logic [IMEM_ADDR_W-1:0] flush_addr_q, flush_addr_d;
  logic [31:0]            stall_inst_q, stall_inst_d;
  logic                   stall_jump_q, stall_jump_d;
  logic                   out_valid_q, out_valid_d;
  logic [31:0]            out_inst_q, out_inst_d;
  logic [IMEM_ADDR_W-1:0] out_pc_q, out_pc_d;
  logic                   out_jump_q, out_jump_d;

  logic flush_req_g, flush_eff, resp_hs, out_free;

  assign flush_req_g = flush_req & ~rst;
  assign flush_eff   = flush_req_g | flush_pending_q;
  assign out_free    = ~out_valid_q | if_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_RST_REQ;
      now_pc_q        <= '0;
      flush_pending_q <= 1'b0;
      flush_addr_q    <= '0;
      stall_inst_q    <= '0;
      stall_jump_q    <= 1'b0;
      out_valid_q     <= 1'b0;
      out_inst_q      <= '0;
      out_pc_q        <= '0;
      out_jump_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      now_pc_q        <= now_pc_d;
      flush_pending_q <= flush_pending_d;
      flush_addr_q    <= flush_addr_d;
      stall_inst_q    <= stall_inst_d;
      stall_jump_q    <= stall_jump_d;
      out_valid_q     <= out_valid_d;
      out_inst_q      <= out_inst_d;
      out_pc_q        <= out_pc_d;
      out_jump_q      <= out_jump_d;
    end
  end

  always_comb begin
    to_rst          = (state_q == ST_RST_REQ);
    imem_req_valid  = (state_q == ST_REQ);
    imem_resp_ready = (state_q == ST_WAIT) & (flush_eff | out_free);
    resp_hs         = imem_resp_valid & imem_resp_ready;
    to_flush        = ((state_q == ST_WAIT) & resp_hs & flush_eff) |
                      ((state_q == ST_JALR_STALL) & flush_eff);
    flush_addr_hold = flush_req_g ? flush_addr : flush_addr_q;
  end

  always_comb begin
    logic       load_out;
    logic [31:0] load_inst;
    logic        load_jump;
    state_d         = state_q;
    now_pc_d        = now_pc_q;
    flush_pending_d = flush_pending_q | flush_req_g;
    flush_addr_d    = flush_req_g ? flush_addr : flush_addr_q;
    stall_inst_d    = stall_inst_q;
    stall_jump_d    = stall_jump_q;
    load_out        = 1'b0;
    load_inst       = imem_resp_inst;
    load_jump       = to_jump;

    case (state_q)
      ST_RST_REQ: begin
        now_pc_d = new_pc;
        state_d  = ST_REQ;
      end
      ST_REQ: begin
        if (imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (resp_hs && !flush_eff) begin
          if (is_jalr_inst && !rs1_vld) begin
            stall_inst_d = imem_resp_inst;
            stall_jump_d = to_jump;
            state_d      = ST_JALR_STALL;
          end else begin
            now_pc_d = new_pc;
            load_out = 1'b1;
            state_d  = ST_REQ;
          end
        end
      end
      ST_JALR_STALL: begin
        if (!flush_eff && rs1_vld && out_free) begin
          now_pc_d  = new_pc;
          load_out  = 1'b1;
          load_inst = stall_inst_q;
          load_jump = stall_jump_q;
          state_d   = ST_REQ;
        end
      end
      default: state_d = ST_RST_REQ;
    endcase

    // A flush discards any fetched or stalled instruction and redirects fetch.
    if (to_flush) begin
      now_pc_d        = new_pc;
      flush_pending_d = 1'b0;
      state_d         = ST_REQ;
    end

    out_inst_d = out_inst_q;
    out_pc_d   = out_pc_q;
    out_jump_d = out_jump_q;
    if (flush_eff) begin
      out_valid_d = 1'b0;
    end else if (load_out) begin
      out_valid_d = 1'b1;
      out_inst_d  = load_inst;
      out_pc_d    = now_pc_q;
      out_jump_d  = load_jump;
    end else if (if_out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  assign now_pc           = now_pc_q;
  assign imem_req_addr    = now_pc_q;
  assign if_out_valid     = out_valid_q;
  assign if_out_inst      = out_inst_q;
  assign if_out_pc        = out_pc_q;
  assign if_out_prdt_jump = out_jump_q;

endmodule

// File: doc/panda_risc_v_pc_seq.md
# panda_risc_v_pc_seq

Fetch-PC sequencer for the panda_risc_v IFU. It owns the architectural fetch PC register and drives the combinational next-PC generator with `to_rst`, `to_flush` and `flush_addr_hold`, then loads the `new_pc` it returns. It issues one instruction-memory request at a time and holds JALR instructions until RS1 is available. Accepted instructions go to decode through a single-entry output register.

## Interface
- `simulation_delay`, 1, register update delay; simulation only, no functional effect.

- `clk` in 1: clock
- `rst` in 1: synchronous reset, active-high
- `rst_pc` in 32: PC loaded on reset release
- `flush_req` in 1: single-cycle flush pulse from backend
- `flush_addr` in 32: flush target, valid with `flush_req`
- `now_pc` out 32: current fetch PC, to next-PC generator
- `to_rst` / `to_flush` out 1: select for next-PC generator
- `flush_addr_hold` out 32: flush target, to next-PC generator
- `new_pc` in 32: next-PC generator result
- `to_jump` in 1: branch prediction of current instruction
- `is_jalr_inst` in 1: predecode of returned instruction
- `rs1_vld` in 1: RS1 value for JALR is available
- `imem_req_valid` / `imem_req_ready` out/in 1: fetch request handshake
- `imem_req_addr` out 32: equals `now_pc`
- `imem_resp_valid` / `imem_resp_ready` in/out 1: fetch response handshake
- `imem_resp_inst` in 32: fetched instruction
- `if_out_valid` / `if_out_ready` out/in 1: decode handshake
- `if_out_inst`, `if_out_pc` out 32 each: buffered instruction and its PC
- `if_out_prdt_jump` out 1: buffered prediction

## Operation
- **States:**
  - RST_REQ: `to_rst`=1; `now_pc`<=`new_pc`; next state is REQ.
  - REQ: `imem_req_valid`=1. On the request handshake, go to WAIT.
  - WAIT: `imem_resp_ready`=1 when `flush_eff` is set, or when `if_out_valid`=0, or when `if_out_ready`=1.
  - JALR_STALL: waits for `rs1_vld`.
- **Flush latch:**
  - `flush_req` sets `flush_pending` and captures `flush_addr`.
  - `flush_eff` = `flush_req` | `flush_pending`.
  - `flush_addr_hold` = `flush_req` ? `flush_addr` : the held address.
  - While `rst`=1, `flush_req` is ignored.
- **WAIT, on the response handshake:**
  - If `flush_eff`: discard the instruction, `to_flush`=1, `now_pc`<=`new_pc`, clear pending, go to REQ.
  - Else if `is_jalr_inst`=1 and `rs1_vld`=0: store the instruction, go to JALR_STALL. `now_pc` is unchanged.
  - Else: `now_pc`<=`new_pc`, load the output register (`if_out_pc` = old `now_pc`), go to REQ.
- **JALR_STALL:**
  - `flush_eff` takes priority: apply the flush (same as in WAIT), drop the stored instruction, go to REQ.
  - Else, when `rs1_vld`=1 and the output register is free or draining: update the PC, load the output register, go to REQ.
- **Handshake and flush rules:**
  - A flush never withdraws a REQ request once it is presented. The flush resolves at the next PC-update point, so at most one wasted fetch results.
  - A flush clears `if_out_valid` on the next cycle. A handshake on `if_out` in the same cycle as `flush_req` still counts.
- `to_flush`=1 only in the cycle in which the flush is applied.
- In REQ/WAIT/JALR_STALL, `to_rst`=0.

## Timing
- **Reset values:** state RST_REQ, `now_pc`=0, `flush_pending`=0, `if_out_valid`=0, `imem_req_valid`=0, `imem_resp_ready`=0. `to_rst`=1 (combinational from state, also during `rst`).
- **Release:** cycle 0 is RST_REQ. Cycle 1 is REQ with `imem_req_addr`=`rst_pc`.
- **Minimum loop:** 2 cycles per instruction. The response is accepted no earlier than the cycle after the request handshake. `if_out_valid` rises the cycle after the response.
- `rst` mid-operation returns to RST_REQ on the next edge. Any outstanding imem transaction is the responsibility of the memory side.
- **Simultaneous events:**
  - `flush_req` in the same cycle as a response: the response is discarded and the new `flush_addr` is used.
  - A second `flush_req` while one is pending overwrites the held address.

## Structure
- Shared package `panda_risc_v_ifu_pkg`: state encoding, and `IMEM_ADDR_W`=32.
- No sub-module. The next-PC generator is external and is connected through the `now_pc` / `to_*` / `new_pc` ports.

## Test plan
- **Reset release:** `rst_pc`=0x0000_0100 -> `to_rst`=1 for 1 cycle, then a request with addr 0x100.
- **Sequential fetch:** `new_pc` returns 0x104 -> `if_out_pc`=0x100, next request addr 0x104. With `imem_req_ready` held at 1, issue rate is one instruction per 2 cycles.
- **Flush during WAIT:** `flush_req`, `flush_addr`=0x2000; response arrives 3 cycles later -> response dropped, `to_flush`=1 in that cycle, next request addr 0x2000, no `if_out_valid`.
- **JALR stall:** `is_jalr_inst`=1, `rs1_vld`=0 for 4 cycles -> no request and `now_pc` held. When `rs1_vld`=1, `new_pc`=0x8000 -> `if_out` emitted and next request addr 0x8000.
- **Backpressure:** `if_out_ready`=0 with `if_out_valid`=1 -> `imem_resp_ready`=0 in WAIT. A flush in this state -> `if_out_valid`=0 next cycle and the response is drained and discarded.
- **Flush coincident with response, and reset mid-WAIT:** flush coincident with a response -> new address used. Reset mid-WAIT -> RST_REQ, `now_pc` reloaded to `rst_pc`.
